// File: rtl/bist_supervisor_pkg.sv
// Shared definitions for the BIST session supervisor: FSM state encoding and
// the golden MISR signatures used by both the BIST top level and the supervisor.
package bist_supervisor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam logic [7:0]  SIG_GOLDEN_8  = 8'hF9;
  localparam logic [15:0] SIG_GOLDEN_16 = 16'h6BD2;

endpackage

// File: rtl/bist_timeout_counter.sv
// Session watchdog: counts enabled cycles since the last clear and flags the
// final permitted cycle so the supervisor can end a hung run.
module bist_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + W'(1);
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/bist_supervisor.sv
// Host-side BIST session manager: launches a run, captures the MISR signature
// on the first fresh rise of bist_end, bounds the run with a timeout and
// keeps saturating run/fail counters.
module bist_supervisor
  import bist_supervisor_pkg::*;
#(
  parameter int                   MISR_BITS       = 8,
  parameter logic [MISR_BITS-1:0] SIGNATURE_VALID = MISR_BITS'(SIG_GOLDEN_8),
  parameter int                   TIMEOUT_CYCLES  = 1024,
  parameter int                   CNT_W           = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 clear_counts,
  output logic                 bist_start,
  input  logic                 bist_end,
  input  logic [MISR_BITS-1:0] signature_in,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 pass,
  output logic                 timeout,
  output logic [MISR_BITS-1:0] signature_q,
  output logic [CNT_W-1:0]     run_count,
  output logic [CNT_W-1:0]     fail_count
);

  state_t state;
  logic   bist_end_q;
  logic   rise;
  logic   expired;

  assign rise = bist_end & ~bist_end_q;

  bist_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  ((state == ST_IDLE) && go),
    .enable (state == ST_WAIT),
    .expired(expired)
  );

  // bist_end is tracked in every state so LAUNCH sees a stale high level
  // and WAIT only reacts to a genuine 0->1 transition.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bist_end_q <= 1'b0;
    else        bist_end_q <= bist_end;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      bist_start   <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      signature_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            state      <= ST_LAUNCH;
            bist_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_LAUNCH: state <= ST_WAIT;
        ST_WAIT: begin
          // A rise on the expiry cycle still counts as a completed run.
          if (rise) begin
            signature_q  <= signature_in;
            pass         <= (signature_in == SIGNATURE_VALID);
            timeout      <= 1'b0;
            state        <= ST_REPORT;
            bist_start   <= 1'b0;
            result_valid <= 1'b1;
          end else if (expired) begin
            pass         <= 1'b0;
            timeout      <= 1'b1;
            state        <= ST_REPORT;
            bist_start   <= 1'b0;
            result_valid <= 1'b1;
          end
        end
        ST_REPORT: begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_count  <= '0;
      fail_count <= '0;
    end else if (clear_counts) begin
      run_count  <= '0;
      fail_count <= '0;
    end else if (state == ST_REPORT) begin
      if (run_count != '1)
        run_count <= run_count + CNT_W'(1);
      if (!pass && (fail_count != '1))
        fail_count <= fail_count + CNT_W'(1);
    end
  end

endmodule
